// File: rtl/data_mem_responder.sv
// data_mem_responder: byte-organised data memory answering 32-bit word
// loads/stores one byte per cycle, big-endian, with wrap-around addressing.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset (clears FSM, outputs and storage)
//   req    : access request, accepted only in IDLE
//   we     : 1 = store, 0 = load (latched with req)
//   addr   : byte address of the word's most-significant byte (latched)
//   wdata  : store data (latched)
//   rdata  : assembled load data, updated one byte per XFER cycle
//   ack    : one-cycle completion pulse (registered)
//   busy   : high while a command is in XFER or DONE (registered)
module data_mem_responder #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  output logic          ack,
  output logic          busy
);

  localparam int unsigned CW = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic            ack_next, busy_next;
  logic            accept_c, xfer_c;

  logic            we_q;
  logic [AW-1:0]   addr_q;
  logic [31:0]     wdata_q;

  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   byte_addr_c;
  logic [7:0]      wr_byte_c;

  // State, byte counter and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      ack   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      ack   <= ack_next;
      busy  <= busy_next;
    end
  end

  // Next-state logic; ack/busy are computed for the state being entered
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    ack_next   = 1'b0;
    busy_next  = 1'b0;
    accept_c   = 1'b0;
    xfer_c     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req) begin
          accept_c   = 1'b1;
          cnt_next   = '0;
          busy_next  = 1'b1;
          state_next = ST_XFER;
        end
      end
      ST_XFER: begin
        xfer_c    = 1'b1;
        busy_next = 1'b1;
        cnt_next  = cnt + CW'(1);
        if (cnt == CW'(3)) begin
          ack_next   = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Command capture; inputs are ignored outside IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept_c) begin
      we_q    <= we;
      addr_q  <= addr;
      wdata_q <= wdata;
    end
  end

  // Byte address wraps naturally in AW bits (DEPTH == 2**AW)
  assign byte_addr_c = addr_q + AW'(cnt);

  // Big-endian lane select: byte 0 is the most-significant byte
  always_comb begin
    wr_byte_c = wdata_q[31:24];
    case (cnt)
      2'd1:    wr_byte_c = wdata_q[23:16];
      2'd2:    wr_byte_c = wdata_q[15:8];
      2'd3:    wr_byte_c = wdata_q[7:0];
      default: wr_byte_c = wdata_q[31:24];
    endcase
  end

  // Storage array, one byte written per XFER cycle on stores
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= 8'h00;
      end
    end else if (xfer_c && we_q) begin
      mem[byte_addr_c] <= wr_byte_c;
    end
  end

  // Load data assembly; untouched lanes keep their previous value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= 32'h0;
    end else if (xfer_c && !we_q) begin
      case (cnt)
        2'd0:    rdata[31:24] <= mem[byte_addr_c];
        2'd1:    rdata[23:16] <= mem[byte_addr_c];
        2'd2:    rdata[15:8]  <= mem[byte_addr_c];
        default: rdata[7:0]   <= mem[byte_addr_c];
      endcase
    end
  end

endmodule
